// File: rtl/simd_issue_driver_if.sv
// Job / instruction / commit / fin bundle between the SIMD issue driver and its neighbours.
// slave = driver side, master = upstream job source plus downstream sink.
interface simd_issue_driver_if #(
    parameter int N_INST    = 16,
    parameter int MAX_WARP  = 8,
    parameter int N_PENDING = 4
);
    localparam int INST_BW = $clog2(N_INST + 1);
    localparam int WID_BW  = $clog2(MAX_WARP);
    localparam int CNT_BW  = $clog2(N_PENDING + 1);

    logic               job_rdy;
    logic               job_ack;
    logic [INST_BW-1:0] i_pc_beg;
    logic [INST_BW-1:0] i_pc_end;
    logic [WID_BW-1:0]  i_nwarp;
    logic               i_last;
    logic               inst_rdy;
    logic               inst_ack;
    logic [INST_BW-1:0] o_pc;
    logic [WID_BW-1:0]  o_warpid;
    logic               inst_commit_dval;
    logic               fin_rdy;
    logic               fin_ack;
    logic [CNT_BW-1:0]  o_pending;

    modport slave (
        input  job_rdy, i_pc_beg, i_pc_end, i_nwarp, i_last,
        input  inst_ack, inst_commit_dval, fin_ack,
        output job_ack, inst_rdy, o_pc, o_warpid, fin_rdy, o_pending
    );

    modport master (
        output job_rdy, i_pc_beg, i_pc_end, i_nwarp, i_last,
        output inst_ack, inst_commit_dval, fin_ack,
        input  job_ack, inst_rdy, o_pc, o_warpid, fin_rdy, o_pending
    );
endinterface

// File: rtl/simd_issue_driver.sv
// Expands (pc range x warp count) jobs into (pc, warpid) issues under an outstanding-instruction credit.
// Latency: job_ack combinational in IDLE, first issue one cycle later, then one issue per cycle.
// Backpressure: issue stalls at N_PENDING uncommitted; fin waits for all commits; jobs refused outside IDLE.
module simd_issue_driver #(
    parameter int N_INST     = 16,
    parameter int MAX_WARP   = 8,
    parameter int N_PENDING  = 4,
    parameter int WARP_INNER = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    simd_issue_driver_if.slave  bus
);
    localparam int INST_BW = $clog2(N_INST + 1);
    localparam int WID_BW  = $clog2(MAX_WARP);
    localparam int CNT_BW  = $clog2(N_PENDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INST_BW-1:0] pc;
    logic [INST_BW-1:0] pc_beg_r;
    logic [INST_BW-1:0] pc_end_r;
    logic [INST_BW-1:0] pc_last;
    logic [WID_BW-1:0]  warpid;
    logic [WID_BW-1:0]  nwarp_r;
    logic               last_r;
    logic [CNT_BW-1:0]  pending;
    logic               job_fire;
    logic               inst_fire;
    logic               fin_fire;
    logic               bypass;
    logic               last_pair;
    logic               commit;

    assign job_fire  = bus.job_rdy & bus.job_ack;
    assign inst_fire = bus.inst_rdy & bus.inst_ack;
    assign fin_fire  = bus.fin_rdy & bus.fin_ack;
    assign bypass    = (bus.i_pc_beg == bus.i_pc_end);
    assign pc_last   = pc_end_r - INST_BW'(1);
    assign last_pair = (pc == pc_last) && (warpid == nwarp_r);
    // A commit with nothing outstanding is ignored so the count cannot underflow.
    assign commit    = bus.inst_commit_dval && (pending != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (job_fire) begin
                    if (!bypass)          state_nxt = ISSUE;
                    else if (bus.i_last)  state_nxt = DRAIN;
                    else                  state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (inst_fire && last_pair) state_nxt = last_r ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (fin_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Credit is judged on the registered count; a same-cycle commit frees the slot next cycle.
    always_comb begin
        bus.job_ack  = 1'b0;
        bus.inst_rdy = 1'b0;
        bus.fin_rdy  = 1'b0;
        case (state)
            IDLE:    bus.job_ack  = bus.job_rdy & i_rst_n;
            ISSUE:   bus.inst_rdy = (pending != CNT_BW'(N_PENDING));
            DRAIN:   bus.fin_rdy  = (pending == '0);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc       <= '0;
            warpid   <= '0;
            pc_beg_r <= '0;
            pc_end_r <= '0;
            nwarp_r  <= '0;
            last_r   <= 1'b0;
        end else if (job_fire) begin
            pc_beg_r <= bus.i_pc_beg;
            pc_end_r <= bus.i_pc_end;
            nwarp_r  <= bus.i_nwarp;
            last_r   <= bus.i_last;
            pc       <= bus.i_pc_beg;
            warpid   <= '0;
        end else if (inst_fire) begin
            if (WARP_INNER != 0) begin
                if (warpid < nwarp_r) begin
                    warpid <= warpid + WID_BW'(1);
                end else begin
                    warpid <= '0;
                    pc     <= pc + INST_BW'(1);
                end
            end else begin
                if (pc < pc_last) begin
                    pc <= pc + INST_BW'(1);
                end else begin
                    pc     <= pc_beg_r;
                    warpid <= warpid + WID_BW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
        end else begin
            case ({inst_fire, commit})
                2'b10:   pending <= pending + CNT_BW'(1);
                2'b01:   pending <= pending - CNT_BW'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign bus.o_pc      = pc;
    assign bus.o_warpid  = warpid;
    assign bus.o_pending = pending;

    a_job_order: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        job_fire |-> (bus.i_pc_beg <= bus.i_pc_end));
    a_commit_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.inst_commit_dval |-> (pending != '0));
    a_pending_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        pending <= CNT_BW'(N_PENDING));
endmodule

// File: tb/tb_simd_issue_driver.sv
// Random job/ack/commit/fin traffic into warp-inner and pc-inner drivers sharing one input stream;
// a queue-based model predicts handshakes and the exact (pc, warpid) order of each instance.
module tb_simd_issue_driver;
    localparam int N_INST    = 16;
    localparam int MAX_WARP  = 8;
    localparam int N_PENDING = 4;
    localparam int INST_BW   = $clog2(N_INST + 1);
    localparam int WID_BW    = $clog2(MAX_WARP);

    typedef struct packed {
        logic [INST_BW-1:0] pc;
        logic [WID_BW-1:0]  wid;
    } pair_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    simd_issue_driver_if #(.N_INST(N_INST), .MAX_WARP(MAX_WARP), .N_PENDING(N_PENDING)) bw ();
    simd_issue_driver_if #(.N_INST(N_INST), .MAX_WARP(MAX_WARP), .N_PENDING(N_PENDING)) bp ();

    simd_issue_driver #(.N_INST(N_INST), .MAX_WARP(MAX_WARP), .N_PENDING(N_PENDING), .WARP_INNER(1))
        dut_w (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bw.slave));
    simd_issue_driver #(.N_INST(N_INST), .MAX_WARP(MAX_WARP), .N_PENDING(N_PENDING), .WARP_INNER(0))
        dut_p (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bp.slave));

    assign bp.job_rdy          = bw.job_rdy;
    assign bp.i_pc_beg         = bw.i_pc_beg;
    assign bp.i_pc_end         = bw.i_pc_end;
    assign bp.i_nwarp          = bw.i_nwarp;
    assign bp.i_last           = bw.i_last;
    assign bp.inst_ack         = bw.inst_ack;
    assign bp.inst_commit_dval = bw.inst_commit_dval;
    assign bp.fin_ack          = bw.fin_ack;

    pair_t qw[$];
    pair_t qp[$];
    int    n_checks = 0;
    int    n_err    = 0;

    // Model: phase 0 idle / 1 issuing / 2 awaiting fin; pairs left in the job; uncommitted count.
    int    mph   = 0;
    int    mrem  = 0;
    int    mpend = 0;
    bit    mlast = 1'b0;
    bit    job_taken = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic new_job();
        int beg;
        int fin;
        if ($urandom_range(99) < 20) begin
            beg = $urandom_range(N_INST);
            fin = beg;
        end else begin
            beg = $urandom_range(N_INST - 1);
            fin = beg + 1 + $urandom_range((N_INST - beg - 1) < 5 ? (N_INST - beg - 1) : 5);
        end
        bw.i_pc_beg = INST_BW'(beg);
        bw.i_pc_end = INST_BW'(fin);
        bw.i_nwarp  = WID_BW'($urandom_range(MAX_WARP - 1));
        bw.i_last   = ($urandom_range(2) == 0);
        bw.job_rdy  = 1'b1;
    endtask

    task automatic accept_job();
        int beg;
        int fin;
        int nw;
        beg = int'(bw.i_pc_beg);
        fin = int'(bw.i_pc_end);
        nw  = int'(bw.i_nwarp);
        for (int p = beg; p < fin; p++)
            for (int w = 0; w <= nw; w++)
                qw.push_back('{pc: INST_BW'(p), wid: WID_BW'(w)});
        for (int w = 0; w <= nw; w++)
            for (int p = beg; p < fin; p++)
                qp.push_back('{pc: INST_BW'(p), wid: WID_BW'(w)});
        mlast = bw.i_last;
        mrem  = (fin - beg) * (nw + 1);
        if (mrem != 0) mph = 1;
        else           mph = mlast ? 2 : 0;
    endtask

    // Called at a falling edge: drive inputs, check handshake outputs, advance model to next cycle.
    task automatic step(input int p_job, input int p_ack, input int p_commit, input int p_fin,
                        input bit allow_job);
        bit exp_rdy;
        bit exp_fin;
        bit exp_jack;
        bit fire;
        bit cmt;
        if (job_taken) begin
            bw.job_rdy = 1'b0;
            job_taken  = 1'b0;
        end
        if (!bw.job_rdy && allow_job && $urandom_range(99) < p_job) new_job();
        bw.inst_ack         = ($urandom_range(99) < p_ack);
        bw.inst_commit_dval = (mpend > 0) && ($urandom_range(99) < p_commit);
        bw.fin_ack          = ($urandom_range(99) < p_fin);
        #1;
        exp_rdy  = (mph == 1) && (mpend < N_PENDING);
        exp_fin  = (mph == 2) && (mpend == 0);
        exp_jack = (mph == 0) && bw.job_rdy;
        chk("w_inst_rdy", 32'(bw.inst_rdy), 32'(exp_rdy));
        chk("p_inst_rdy", 32'(bp.inst_rdy), 32'(exp_rdy));
        chk("w_fin_rdy", 32'(bw.fin_rdy), 32'(exp_fin));
        chk("p_fin_rdy", 32'(bp.fin_rdy), 32'(exp_fin));
        chk("w_job_ack", 32'(bw.job_ack), 32'(exp_jack));
        chk("p_job_ack", 32'(bp.job_ack), 32'(exp_jack));
        chk("w_pending", 32'(bw.o_pending), 32'(mpend));
        chk("p_pending", 32'(bp.o_pending), 32'(mpend));
        fire = exp_rdy && bw.inst_ack;
        cmt  = bw.inst_commit_dval;
        if (exp_jack) begin
            accept_job();
            job_taken = 1'b1;
        end else if (fire) begin
            mrem--;
            if (mrem == 0) mph = mlast ? 2 : 0;
        end else if (exp_fin && bw.fin_ack) begin
            mph = 0;
        end
        mpend = mpend + (fire ? 1 : 0) - (cmt ? 1 : 0);
        @(negedge i_clk);
    endtask

    // Scoreboard monitor: every accepted instruction must match the head of its expected queue.
    initial begin
        pair_t e;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst_n && bw.inst_rdy && bw.inst_ack) begin
                if (qw.size() == 0) chk("w_extra_issue", {bw.o_pc, bw.o_warpid}, 32'hFFFF_FFFF);
                else begin
                    e = qw.pop_front();
                    chk("w_pair", 32'({bw.o_pc, bw.o_warpid}), 32'(e));
                end
            end
            if (i_rst_n && bp.inst_rdy && bp.inst_ack) begin
                if (qp.size() == 0) chk("p_extra_issue", {bp.o_pc, bp.o_warpid}, 32'hFFFF_FFFF);
                else begin
                    e = qp.pop_front();
                    chk("p_pair", 32'({bp.o_pc, bp.o_warpid}), 32'(e));
                end
            end
        end
    end

    initial begin
        int waited;
        bw.job_rdy = 1'b0;
        bw.i_pc_beg = '0;
        bw.i_pc_end = '0;
        bw.i_nwarp = '0;
        bw.i_last = 1'b0;
        bw.inst_ack = 1'b0;
        bw.inst_commit_dval = 1'b0;
        bw.fin_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        bw.job_rdy = 1'b1;
        #1;
        chk("rst_job_ack", 32'(bw.job_ack), 32'd0);
        chk("rst_inst_rdy", 32'(bw.inst_rdy), 32'd0);
        chk("rst_fin_rdy", 32'(bw.fin_rdy), 32'd0);
        chk("rst_pc", 32'(bw.o_pc), 32'd0);
        chk("rst_warpid", 32'(bw.o_warpid), 32'd0);
        chk("rst_pending", 32'(bp.o_pending), 32'd0);
        bw.job_rdy = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) step(30, 100, 50, 50, 1'b1);
        for (int i = 0; i < 1500; i++) step(40, 70, 20, 60, 1'b1);
        for (int i = 0; i < 40; i++)   step(60, 100, 0, 50, 1'b1);
        for (int i = 0; i < 200; i++)  step(40, 80, 60, 50, 1'b1);

        // Reset in the middle of issuing: everything returns to idle at once.
        waited = 0;
        while (!(mph == 1 && mpend > 0) && waited < 3000) begin
            step(50, 60, 10, 50, 1'b1);
            waited++;
        end
        chk("reach_issue_timeout", 32'(waited < 3000), 32'd1);
        if (job_taken) begin
            bw.job_rdy = 1'b0;
            job_taken = 1'b0;
        end
        i_rst_n = 1'b0;
        bw.inst_commit_dval = 1'b0;
        if (!bw.job_rdy) new_job();
        #1;
        chk("midrst_w_inst_rdy", 32'(bw.inst_rdy), 32'd0);
        chk("midrst_p_inst_rdy", 32'(bp.inst_rdy), 32'd0);
        chk("midrst_pending", 32'(bw.o_pending), 32'd0);
        chk("midrst_job_ack", 32'(bw.job_ack), 32'd0);
        chk("midrst_pc", 32'(bp.o_pc), 32'd0);
        qw.delete();
        qp.delete();
        mph = 0;
        mpend = 0;
        mrem = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) step(35, 75, 40, 50, 1'b1);
        for (int i = 0; i < 400; i++)  step(0, 100, 100, 100, 1'b0);
        chk("w_queue_empty", 32'(qw.size()), 32'd0);
        chk("p_queue_empty", 32'(qp.size()), 32'd0);
        chk("model_idle", 32'(mph), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
